// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-memory bridge: FSM encoding and bus constants.
package bus_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRamWait = 2'd1,
        StIoWait  = 2'd2,
        StResp    = 2'd3
    } state_e;

    localparam logic [31:0] DeadBeef      = 32'hDEAD_BEEF;
    localparam logic [31:0] IoBaseDefault = 32'hFFFF_0000;
    localparam int unsigned CntW          = 16;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that saturates at zero; paces both RAM latency and IO timeout.
module wait_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_mem_bridge.sv
// Single-outstanding bridge from a CPU request port to an external synchronous RAM
// and a memory-mapped IO region with a bounded wait.
module cpu_mem_bridge
    import bus_pkg::*;
#(
    parameter int unsigned RAM_AW     = 12,
    parameter int unsigned RAM_LAT    = 1,
    parameter logic [31:0] IO_BASE    = IoBaseDefault,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       data_from_cpu,
    input  logic [3:0]        be,
    output logic [31:0]       data_to_cpu,
    output logic              mio_ready,
    output logic              bus_err,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic              io_sel,
    output logic              io_we,
    output logic [15:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ready
);

    // A read waits RAM_LAT+1 cycles so ram_dout is sampled one edge after the RAM produces it.
    localparam logic [CntW-1:0] RamRdLoad = CntW'(RAM_LAT);
    localparam logic [CntW-1:0] RamWrLoad = CntW'(1);
    localparam logic [CntW-1:0] IoLoad    = CntW'(IO_TIMEOUT - 1);

    state_e state_q, state_d;

    logic        wr_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;

    logic            req;
    logic            req_io;
    logic            accept;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
    logic [CntW-1:0] cnt_val;

    assign req    = mem_r | mem_w;
    assign req_io = (addr_in >= IO_BASE);
    assign accept = (state_q == StIdle) && req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req) state_d = req_io ? StIoWait : StRamWait;
            StRamWait: if (cnt_zero) state_d = StResp;
            StIoWait:  if (io_ready || cnt_zero) state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        mio_ready = (state_q == StResp);
        bus_err   = (state_q == StResp) && err_q;
        // Write enables only on the first RAM_WAIT cycle, while the write count is still 1.
        ram_we    = ((state_q == StRamWait) && wr_q && !cnt_zero) ? be_q : 4'h0;
        io_sel    = (state_q == StIoWait);
        io_we     = (state_q == StIoWait) && wr_q;
    end

    assign cnt_load = accept;
    assign cnt_val  = req_io ? IoLoad : (mem_w ? RamWrLoad : RamRdLoad);
    assign cnt_dec  = (state_q == StRamWait) || (state_q == StIoWait);

    wait_counter #(
        .Width (CntW)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= mem_w;
                err_q   <= 1'b0;
                addr_q  <= addr_in;
                wdata_q <= data_from_cpu;
                be_q    <= be;
            end
            if ((state_q == StRamWait) && cnt_zero && !wr_q) begin
                rdata_q <= ram_dout;
            end
            // io_ready on the last allowed cycle still wins over the timeout.
            if (state_q == StIoWait) begin
                if (io_ready) begin
                    if (!wr_q) rdata_q <= io_rdata;
                end else if (cnt_zero) begin
                    err_q <= 1'b1;
                    if (!wr_q) rdata_q <= DeadBeef;
                end
            end
        end
    end

    assign data_to_cpu = rdata_q;
    assign ram_addr    = addr_q[RAM_AW+1:2];
    assign ram_din     = wdata_q;
    assign io_addr     = addr_q[15:0];
    assign io_wdata    = wdata_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Randomized bench for cpu_mem_bridge: transaction-level model of latency, data and IO
// behaviour, an external RAM, and one per-cycle compare process.
module tb_cpu_mem_bridge;

    localparam int unsigned RamAw     = 12;
    localparam int          RamLat    = 1;
    localparam int          IoTimeout = 15;
    localparam logic [31:0] IoBase    = 32'hFFFF_0000;

    logic              clk;
    logic              reset;
    logic              mem_r;
    logic              mem_w;
    logic [31:0]       addr_in;
    logic [31:0]       data_from_cpu;
    logic [3:0]        be;
    logic [31:0]       data_to_cpu;
    logic              mio_ready;
    logic              bus_err;
    logic [3:0]        ram_we;
    logic [RamAw-1:0]  ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic              io_sel;
    logic              io_we;
    logic [15:0]       io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;
    logic              io_ready;

    cpu_mem_bridge #(
        .RAM_AW     (RamAw),
        .RAM_LAT    (RamLat),
        .IO_BASE    (IoBase),
        .IO_TIMEOUT (IoTimeout)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_r         (mem_r),
        .mem_w         (mem_w),
        .addr_in       (addr_in),
        .data_from_cpu (data_from_cpu),
        .be            (be),
        .data_to_cpu   (data_to_cpu),
        .mio_ready     (mio_ready),
        .bus_err       (bus_err),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .io_sel        (io_sel),
        .io_we         (io_we),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_rdata      (io_rdata),
        .io_ready      (io_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External synchronous RAM, one cycle read latency.
    logic [31:0] ram [4096];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_dout <= ram[ram_addr];
    end

    // Reference model state
    logic [31:0] ref_mem [4096];
    int          resp_at = -1;
    int          we_at = -1;
    int          io_lo = -1;
    int          io_hi = -2;
    int          rst_at = -1;
    int          last_accept = 0;
    int          last_ready = -1;
    logic        err_seen = 1'b0;
    logic        exp_rd = 1'b0;
    logic        exp_wr = 1'b0;
    logic        exp_err = 1'b0;
    logic [3:0]  we_be = 4'h0;
    logic [31:0] data_new = '0;
    logic [31:0] data_exp = '0;
    logic [15:0] exp_io_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [11:0] exp_ram_addr = '0;
    logic        checking = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            logic sel;
            if (cyc == rst_at) data_exp = '0;
            if ((cyc == resp_at) && exp_rd) data_exp = data_new;
            sel = (io_lo >= 0) && (cyc >= io_lo) && (cyc <= io_hi);
            check("mio_ready", 32'(mio_ready), 32'(cyc == resp_at));
            check("bus_err", 32'(bus_err), 32'((cyc == resp_at) && exp_err));
            check("data_to_cpu", data_to_cpu, data_exp);
            check("ram_we", 32'(ram_we), (cyc == we_at) ? 32'(we_be) : 32'd0);
            if (cyc == we_at) begin
                check("ram_addr", 32'(ram_addr), 32'(exp_ram_addr));
                check("ram_din", ram_din, exp_wdata);
            end
            check("io_sel", 32'(io_sel), 32'(sel));
            check("io_we", 32'(io_we), 32'(sel && exp_wr));
            if (sel) begin
                check("io_addr", 32'(io_addr), 32'(exp_io_addr));
                if (exp_wr) check("io_wdata", io_wdata, exp_wdata);
            end
            if (mio_ready) last_ready = cyc;
            if (bus_err) err_seen = 1'b1;
        end
    end

    // One CPU access; io_k is the IO_WAIT cycle (1-based) in which io_ready is raised.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] bev, input int io_k,
                          input logic hold);
        logic is_io;
        int   a;
        int   lat;
        int   idx;
        @(negedge clk); #1;
        is_io = (addr >= IoBase);
        mem_r = rd;
        mem_w = wr;
        addr_in = addr;
        data_from_cpu = wd;
        be = bev;
        io_rdata = $urandom;
        a = cyc + 1;
        exp_wr = wr;
        exp_rd = !wr;
        exp_err = 1'b0;
        err_seen = 1'b0;
        exp_io_addr = addr[15:0];
        exp_wdata = wd;
        exp_ram_addr = addr[13:2];
        if (is_io) begin
            lat = (io_k <= IoTimeout) ? io_k : IoTimeout;
            exp_err = (io_k > IoTimeout);
            data_new = exp_err ? 32'hDEAD_BEEF : io_rdata;
            we_at = -1;
            io_lo = a;
            io_hi = a + lat - 1;
        end else begin
            idx = int'(addr[13:2]);
            lat = wr ? 2 : RamLat + 1;
            data_new = ref_mem[idx];
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (bev[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
            we_at = wr ? a : -1;
            we_be = bev;
            io_lo = -1;
            io_hi = -2;
        end
        resp_at = a + lat;
        last_accept = a;
        @(negedge clk); #1;
        for (int n = 0; n < 64; n++) begin
            if (!hold || (cyc >= resp_at)) begin
                mem_r = 1'b0;
                mem_w = 1'b0;
            end
            io_ready = is_io ? (cyc == a + io_k - 1) : 1'($urandom_range(0, 1));
            if (cyc >= resp_at) break;
            @(negedge clk); #1;
        end
        io_ready = 1'b0;
    endtask

    task automatic reset_mid(input logic [31:0] addr);
        int a;
        @(negedge clk); #1;
        mem_r = 1'b1;
        mem_w = 1'b0;
        addr_in = addr;
        a = cyc + 1;
        exp_wr = 1'b0;
        exp_rd = 1'b1;
        exp_err = 1'b0;
        we_at = -1;
        io_lo = -1;
        io_hi = -2;
        resp_at = a + RamLat + 1;
        @(negedge clk); #1;
        reset = 1'b1;
        mem_r = 1'b0;
        resp_at = -1;
        rst_at = cyc + 1;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a32;
        int          kind;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        mem_r = 1'b0;
        mem_w = 1'b0;
        addr_in = '0;
        data_from_cpu = '0;
        be = '0;
        io_rdata = '0;
        io_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        checking = 1'b1;

        access(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0);
        check("read_0x40", data_to_cpu, 32'h1234_5678);
        check("read_latency", 32'(last_ready - last_accept), 32'd2);

        access(1'b0, 1'b1, 32'h0000_0080, 32'h0, 4'hF, 0, 1'b0);
        access(1'b0, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'b0010, 0, 1'b1);
        check("write_latency", 32'(last_ready - last_accept), 32'd2);
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, 1'b0);
        check("byte_enable", data_to_cpu, 32'h0000_FF00);

        access(1'b1, 1'b0, 32'h0000_4040, 32'h0, 4'h0, 0, 1'b1);
        check("alias_0x4040", data_to_cpu, 32'h1234_5678);

        access(1'b1, 1'b0, 32'hFFFF_0010, 32'h0, 4'h0, 100, 1'b0);
        check("timeout_data", data_to_cpu, 32'hDEAD_BEEF);
        check("timeout_latency", 32'(last_ready - last_accept), 32'd15);
        check("timeout_err", 32'(err_seen), 32'd1);

        access(1'b1, 1'b0, 32'hFFFF_0020, 32'h0, 4'h0, 15, 1'b0);
        check("late_ready_no_err", 32'(err_seen), 32'd0);
        check("late_ready_data", data_to_cpu, io_rdata);

        access(1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 4'hF, 0, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1'b0);
        check("both_high_is_write", data_to_cpu, 32'hA5A5_5A5A);

        access(1'b0, 1'b1, 32'hFFFF_1234, 32'hCAFE_F00D, 4'hF, 3, 1'b0);
        check("io_write_latency", 32'(last_ready - last_accept), 32'd3);

        reset_mid(32'h0000_0040);
        check("reset_clears_data", data_to_cpu, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0);
        check("after_reset_read", data_to_cpu, 32'h1234_5678);

        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                a32 = ($urandom & 32'h7FFF_C000) | (32'($urandom_range(0, 31)) << 2);
            end else begin
                a32 = IoBase | 32'($urandom_range(0, 16'hFFFF));
            end
            if (kind == 0 || kind == 2) begin
                access(1'b1, 1'b0, a32, $urandom, 4'($urandom), $urandom_range(1, 18),
                       1'($urandom_range(0, 1)));
            end else begin
                access(1'($urandom_range(0, 1)), 1'b1, a32, $urandom, 4'($urandom),
                       $urandom_range(1, 18), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
